edge_frame_sequencer: RTL and testbench
=======================================

Name: edge_frame_sequencer

Overview:
Frame-level controller for the Sobel edge-detection core. It accepts a start command with source and destination base addresses. It serves the core's pixel requests (next_pixel_x/y) from a source memory over an Avalon-MM read master, with zero padding outside the frame. It captures the core's results and writes saturated magnitudes to a destination frame buffer over an Avalon-MM write master, then pulses done once the core reports sync and all results are written.

Parameters:
COL_NUM, 640, frame width in pixels
ROW_NUM, 480, frame height in pixels
ADDR_W, 19, byte address width of both memories
COORD_W, 11, signed coordinate/result width used by the core
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  frame start pulse, honoured only in IDLE
base_src  in  ADDR_W  source frame base, latched on accepted start
base_dst  in  ADDR_W  destination frame base, latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame completion
range_err  out  1  sticky: a result with out-of-frame coordinates was dropped; cleared on accepted start
src_read  out  1  Avalon read request
src_address  out  ADDR_W  read address
src_waitrequest  in  1  read stall
src_readdata  in  8  read data
src_readdatavalid  in  1  read data valid
core_en  out  1  enable to edge core
core_waitrequest  out  1  high = pixel not ready, core must hold
core_pixel  out  8  pixel for current request, valid when core_waitrequest low
core_next_x  in  COORD_W signed  requested pixel column
core_next_y  in  COORD_W signed  requested pixel row
core_sync  in  1  core finished frame
core_read_valid  in  1  result valid
core_out_x  in  COORD_W signed  result column
core_out_y  in  COORD_W signed  result row
core_pixel_out  in  COORD_W signed  result value
dst_write  out  1  Avalon write request
dst_address  out  ADDR_W  write address
dst_writedata  out  8  write data
dst_waitrequest  in  1  write stall

Behaviour:
- Reset: all outputs 0, except core_waitrequest=1. FIFO flushed, FSM to IDLE. Reset mid-frame abandons any in-flight read or write without completing it.
- FSM states: IDLE, REQ, ISSUE, WAIT_DATA, FEED, DRAIN, DONE.
- IDLE: on start, latch bases, clear range_err, set core_en=1, go to REQ. start in any other state is ignored.
- REQ:
  - core_sync=1 -> core_en=0 next cycle, go to DRAIN.
  - Otherwise, if the FIFO has <2 free entries, stay in REQ.
  - Otherwise, if coordinates are out of frame (x<0, x>=COL_NUM, y<0, y>=ROW_NUM), latch pixel 0 and go to FEED with no memory access.
  - Otherwise, go to ISSUE.
- ISSUE: src_read=1, src_address=base_src + y*COL_NUM + x (truncated to ADDR_W). Address and read stay stable until a cycle with src_waitrequest=0, then go to WAIT_DATA.
- WAIT_DATA: on src_readdatavalid, latch src_readdata and go to FEED. One read outstanding at most.
- FEED: core_waitrequest=0 for exactly one cycle with core_pixel=latched value, then go to REQ. core_waitrequest is 1 in all other states. Request-to-feed latency: 1 cycle (padded) or 3 + wait cycles (memory).
- Result capture: a result is sampled on any cycle with core_read_valid=1.
  - In-frame result: push {base_dst + out_y*COL_NUM + out_x, sat(|core_pixel_out|)} into the FIFO. sat clamps to 255, and |-1024| maps to 255.
  - Out-of-frame result: dropped, range_err set.
  - The core emits at most one result per fed pixel, so the 2-free-entry check prevents overflow. A push into a full FIFO is a design error (assertion).
- Write side, independent of the FSM: while the FIFO is non-empty, dst_write=1 with the head entry. Pop on a cycle with dst_waitrequest=0. A push and a pop in the same cycle are both honoured.
- DRAIN: wait for the FIFO to be empty and dst_write=0, then go to DONE.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.

Decomposition:
- Package edge_seq_pkg:
  - seq_state_t enum
  - result_entry_t struct {addr, data}
  - functions sat_mag8() and pix_addr()
  - COL_NUM and ROW_NUM defaults shared with the edge core package
- One sub-module: edge_result_fifo, a synchronous FIFO of result_entry_t with depth FIFO_DEPTH, count output, and simultaneous push/pop.

Test Plan (COL_NUM=4, ROW_NUM=3, behavioural core model):
- start with base_src=0x100, base_dst=0x200, no waits -> src reads 0x100..0x10B each once, 12 writes to 0x200..0x20B, done pulses once, busy falls with done.
- Core requests (-1,0) and (4,2) -> no src_read issued, core_pixel=0 with core_waitrequest low for one cycle each.
- src_waitrequest held 5 cycles on address 0x105 -> src_address stable throughout, core_waitrequest stays 1, the correct pixel is fed afterwards.
- dst_waitrequest held 20 cycles -> FIFO fills, REQ stalls, no entry is lost or duplicated, all 12 writes complete in coordinate order.
- Results of -300, 300, -1024, 17 -> writedata 255, 255, 255, 17. A result at (5,0) is dropped and range_err=1 until the next start.
- rst asserted in WAIT_DATA -> next cycle all outputs at reset values and FSM in IDLE; a new start then completes a full frame correctly.

Source files
------------

// File: rtl/edge_seq_pkg.sv
// Shared types and helpers for the edge frame sequencer.
// Frame geometry defaults match the edge core package.
package edge_seq_pkg;

  localparam int DEF_COL_NUM = 640;
  localparam int DEF_ROW_NUM = 480;
  localparam int DEF_ADDR_W  = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT_DATA,
    S_FEED,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } result_entry_t;

  // |v| clamped to a byte; the most negative input also clamps.
  function automatic logic [7:0] sat_mag8(
    input logic signed [31:0] v
  );
    logic [31:0] m;
    m = v[31] ? 32'(-v) : 32'(v);
    return (m > 32'd255) ? 8'hFF : m[7:0];
  endfunction

  function automatic logic [31:0] pix_addr(
    input logic [31:0]        base,
    input logic signed [31:0] x,
    input logic signed [31:0] y,
    input int                 cols
  );
    return base + 32'(y) * 32'(cols) + 32'(x);
  endfunction

endpackage

// File: rtl/edge_result_fifo.sv
// Synchronous FIFO of result entries with occupancy count.
// A push and a pop in the same cycle are both honoured.
module edge_result_fifo
  import edge_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  result_entry_t i_din,
  input  logic          i_pop,
  output result_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = $clog2(DEPTH);

  result_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rp];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Upstream flow control guarantees room for every result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && o_full && !i_pop));
    end
  end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame controller for the Sobel edge core: serves pixel requests
// from a source buffer and writes saturated results to a destination.
module edge_frame_sequencer
  import edge_seq_pkg::*;
#(
  parameter int COL_NUM    = DEF_COL_NUM,
  parameter int ROW_NUM    = DEF_ROW_NUM,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_src,
  input  logic [ADDR_W-1:0]         base_dst,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err,
  output logic                      src_read,
  output logic [ADDR_W-1:0]         src_address,
  input  logic                      src_waitrequest,
  input  logic [7:0]                src_readdata,
  input  logic                      src_readdatavalid,
  output logic                      core_en,
  output logic                      core_waitrequest,
  output logic [7:0]                core_pixel,
  input  logic signed [COORD_W-1:0] core_next_x,
  input  logic signed [COORD_W-1:0] core_next_y,
  input  logic                      core_sync,
  input  logic                      core_read_valid,
  input  logic signed [COORD_W-1:0] core_out_x,
  input  logic signed [COORD_W-1:0] core_out_y,
  input  logic signed [COORD_W-1:0] core_pixel_out,
  output logic                      dst_write,
  output logic [ADDR_W-1:0]         dst_address,
  output logic [7:0]                dst_writedata,
  input  logic                      dst_waitrequest
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_bsrc;
  logic [ADDR_W-1:0] r_bdst;
  logic [ADDR_W-1:0] r_src_addr;
  logic [7:0]        r_pix;
  logic              r_core_en;
  logic              r_range_err;

  logic signed [31:0] w_nx;
  logic signed [31:0] w_ny;
  logic signed [31:0] w_ox;
  logic signed [31:0] w_oy;
  logic signed [31:0] w_ov;
  logic               w_req_in;
  logic               w_res_in;
  logic               w_room;
  logic [ADDR_W-1:0]  w_req_addr;

  result_entry_t w_din;
  result_entry_t w_head;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_nx = 32'(core_next_x);
  assign w_ny = 32'(core_next_y);
  assign w_ox = 32'(core_out_x);
  assign w_oy = 32'(core_out_y);
  assign w_ov = 32'(core_pixel_out);

  assign w_req_in = (w_nx >= 0) && (w_nx < COL_NUM) &&
                    (w_ny >= 0) && (w_ny < ROW_NUM);
  assign w_res_in = (w_ox >= 0) && (w_ox < COL_NUM) &&
                    (w_oy >= 0) && (w_oy < ROW_NUM);

  assign w_req_addr = ADDR_W'(pix_addr(32'(r_bsrc), w_nx, w_ny, COL_NUM));

  // Two free slots cover the result of the previous pixel plus this one.
  assign w_room = (int'(w_count) + 2) <= FIFO_DEPTH;

  always_comb begin
    w_din      = '0;
    w_din.addr = DEF_ADDR_W'(pix_addr(32'(r_bdst), w_ox, w_oy, COL_NUM));
    w_din.data = sat_mag8(w_ov);
  end

  assign w_push = core_read_valid && w_res_in;
  assign w_pop  = !w_empty && !dst_waitrequest;

  edge_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bsrc      <= '0;
      r_bdst      <= '0;
      r_src_addr  <= '0;
      r_pix       <= '0;
      r_core_en   <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if (core_read_valid && !w_res_in) r_range_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bsrc      <= base_src;
            r_bdst      <= base_dst;
            r_range_err <= 1'b0;
            r_core_en   <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (core_sync) begin
            r_core_en <= 1'b0;
            r_state   <= S_DRAIN;
          end else if (w_room) begin
            if (!w_req_in) begin
              r_pix   <= '0;
              r_state <= S_FEED;
            end else begin
              r_src_addr <= w_req_addr;
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!src_waitrequest) r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (src_readdatavalid) begin
            r_pix   <= src_readdata;
            r_state <= S_FEED;
          end
        end
        S_FEED:  r_state <= S_REQ;
        S_DRAIN: begin
          if (w_empty) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign range_err        = r_range_err;
  assign src_read         = (r_state == S_ISSUE);
  assign src_address      = r_src_addr;
  assign core_en          = r_core_en;
  assign core_waitrequest = (r_state != S_FEED);
  assign core_pixel       = r_pix;
  assign dst_write        = !w_empty;
  assign dst_address      = w_empty ? '0 : ADDR_W'(w_head.addr);
  assign dst_writedata    = w_empty ? '0 : w_head.data;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Randomized bench for edge_frame_sequencer with memory and core
// models; expectations come from a raster-order reference model.
module tb_edge_frame_sequencer;

  localparam int COLS    = 4;
  localparam int ROWS    = 3;
  localparam int ADDR_W  = 19;
  localparam int COORD_W = 11;

  typedef struct {
    int x;
    int y;
    int v;
  } req_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] base_src = '0;
  logic [ADDR_W-1:0] base_dst = '0;
  logic busy, done, range_err;
  logic src_read;
  logic [ADDR_W-1:0] src_address;
  logic src_waitrequest = 1'b0;
  logic [7:0] src_readdata = '0;
  logic src_readdatavalid = 1'b0;
  logic core_en, core_waitrequest;
  logic [7:0] core_pixel;
  logic signed [COORD_W-1:0] core_next_x = '0;
  logic signed [COORD_W-1:0] core_next_y = '0;
  logic core_sync = 1'b0;
  logic core_read_valid = 1'b0;
  logic signed [COORD_W-1:0] core_out_x = '0;
  logic signed [COORD_W-1:0] core_out_y = '0;
  logic signed [COORD_W-1:0] core_pixel_out = '0;
  logic dst_write;
  logic [ADDR_W-1:0] dst_address;
  logic [7:0] dst_writedata;
  logic dst_waitrequest = 1'b0;

  edge_frame_sequencer #(
    .COL_NUM    (COLS),
    .ROW_NUM    (ROWS),
    .ADDR_W     (ADDR_W),
    .COORD_W    (COORD_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_src          (base_src),
    .base_dst          (base_dst),
    .busy              (busy),
    .done              (done),
    .range_err         (range_err),
    .src_read          (src_read),
    .src_address       (src_address),
    .src_waitrequest   (src_waitrequest),
    .src_readdata      (src_readdata),
    .src_readdatavalid (src_readdatavalid),
    .core_en           (core_en),
    .core_waitrequest  (core_waitrequest),
    .core_pixel        (core_pixel),
    .core_next_x       (core_next_x),
    .core_next_y       (core_next_y),
    .core_sync         (core_sync),
    .core_read_valid   (core_read_valid),
    .core_out_x        (core_out_x),
    .core_out_y        (core_out_y),
    .core_pixel_out    (core_pixel_out),
    .dst_write         (dst_write),
    .dst_address       (dst_address),
    .dst_writedata     (dst_writedata),
    .dst_waitrequest   (dst_waitrequest)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit in_frame(input int x, input int y);
    return x >= 0 && x < COLS && y >= 0 && y < ROWS;
  endfunction

  function automatic int ref_sat(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 255) ? 255 : a;
  endfunction

  logic [7:0] mem [4096];
  req_t reqs[$];
  int   exp_rd[$];
  wr_t  exp_wr[$];
  int   ridx, cur_bsrc, cur_bdst;
  bit   src_rand, dst_rand;
  int   lat_max, dst_stall, hold_cnt, done_cnt, rd_acc_evt;
  logic [ADDR_W-1:0] hold_addr;

  bit rd_pend, res_pend, prev_rd_stall, prev_done;
  int rd_cnt;
  logic [ADDR_W-1:0] rd_addr, prev_addr;
  req_t res_r;

  // Memory, core and write-sink models; inputs change on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 0; res_pend = 0; prev_rd_stall = 0; prev_done = 0;
      src_readdatavalid = 0; core_read_valid = 0; core_sync = 0;
      src_waitrequest = 0; dst_waitrequest = 0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("busy_with_done", 64'(busy), 1);
      end
      if (prev_done) chk("busy_after_done", 64'(busy), 0);
      prev_done = done;

      src_readdatavalid = 0;
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          src_readdatavalid = 1;
          src_readdata = mem[12'(rd_addr)];
          rd_pend = 0;
        end
      end
      if (prev_rd_stall)
        chk("src_addr_stable", 64'({src_read, src_address}),
            64'({1'b1, prev_addr}));
      if (src_read) chk("wait_during_read", 64'(core_waitrequest), 1);
      if (src_read && src_address == hold_addr && hold_cnt < 5) begin
        src_waitrequest = 1;
        hold_cnt++;
      end else begin
        src_waitrequest = src_rand && ($urandom_range(0, 2) == 0);
      end
      if (src_read && !src_waitrequest) begin
        if (exp_rd.size() == 0) chk("extra_read", 1, 0);
        else chk("src_address", 64'(src_address), 64'(exp_rd.pop_front()));
        rd_pend = 1;
        rd_addr = src_address;
        rd_cnt  = int'($urandom_range(1, lat_max));
        if (lat_max == 3) rd_cnt = 3;
        rd_acc_evt++;
      end
      prev_rd_stall = src_read && src_waitrequest;
      prev_addr = src_address;

      if (dst_stall > 0) begin
        dst_waitrequest = 1;
        dst_stall--;
      end else begin
        dst_waitrequest = dst_rand && ($urandom_range(0, 2) == 0);
      end
      if (dst_write && !dst_waitrequest) begin
        if (exp_wr.size() == 0) chk("extra_write", 1, 0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("dst_address", 64'(dst_address), 64'(w.addr));
          chk("dst_writedata", 64'(dst_writedata), 64'(w.data));
        end
      end

      core_read_valid = 0;
      if (res_pend) begin
        core_read_valid = 1;
        core_out_x = COORD_W'(res_r.x);
        core_out_y = COORD_W'(res_r.y);
        core_pixel_out = COORD_W'(res_r.v);
        res_pend = 0;
      end
      if (core_sync && !core_en) core_sync = 0;
      if (!core_waitrequest) begin
        if (ridx >= reqs.size()) chk("extra_feed", 1, 0);
        else begin
          int e;
          res_r = reqs[ridx];
          e = in_frame(res_r.x, res_r.y) ?
              int'(mem[12'(cur_bsrc + res_r.y * COLS + res_r.x)]) : 0;
          chk("core_pixel", 64'(core_pixel), 64'(e));
          res_pend = 1;
          ridx++;
          if (ridx < reqs.size()) begin
            core_next_x = COORD_W'(reqs[ridx].x);
            core_next_y = COORD_W'(reqs[ridx].y);
          end else begin
            core_sync = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_range_err"}, 64'(range_err), 0);
    chk({tag, "_src_read"}, 64'(src_read), 0);
    chk({tag, "_src_address"}, 64'(src_address), 0);
    chk({tag, "_core_en"}, 64'(core_en), 0);
    chk({tag, "_core_wait"}, 64'(core_waitrequest), 1);
    chk({tag, "_core_pixel"}, 64'(core_pixel), 0);
    chk({tag, "_dst_write"}, 64'(dst_write), 0);
    chk({tag, "_dst_address"}, 64'(dst_address), 0);
    chk({tag, "_dst_writedata"}, 64'(dst_writedata), 0);
  endtask

  task automatic build(input int bsrc, input int bdst, input bit oob,
                       input bit special);
    int sp[4];
    int k;
    sp = '{-300, 300, -1024, 17};
    reqs.delete(); exp_rd.delete(); exp_wr.delete();
    cur_bsrc = bsrc; cur_bdst = bdst; k = 0;
    if (oob) reqs.push_back('{-1, 0, 40});
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        req_t r;
        r.x = x; r.y = y;
        r.v = (special && k < 4) ? sp[k] :
              int'($urandom_range(0, 2047)) - 1024;
        reqs.push_back(r);
        k++;
        if (oob && k == 6) reqs.push_back('{4, 2, 5});
      end
    end
    if (oob) reqs.push_back('{5, 0, 99});
    foreach (reqs[i]) begin
      if (in_frame(reqs[i].x, reqs[i].y)) begin
        wr_t w;
        exp_rd.push_back(bsrc + reqs[i].y * COLS + reqs[i].x);
        w.addr = bdst + reqs[i].y * COLS + reqs[i].x;
        w.data = ref_sat(reqs[i].v);
        exp_wr.push_back(w);
      end
    end
    ridx = 0; done_cnt = 0; hold_cnt = 0;
    core_next_x = COORD_W'(reqs[0].x);
    core_next_y = COORD_W'(reqs[0].y);
  endtask

  task automatic pulse_start(input int bsrc, input int bdst);
    start = 1;
    base_src = ADDR_W'(bsrc);
    base_dst = ADDR_W'(bdst);
    tick();
    start = 0;
  endtask

  task automatic run_frame(input int bsrc, input int bdst, input bit oob,
                           input bit special, input bit restart);
    int cyc;
    build(bsrc, bdst, oob, special);
    pulse_start(bsrc, bdst);
    chk("busy_after_start", 64'(busy), 1);
    chk("range_err_cleared", 64'(range_err), 0);
    chk("core_en_after_start", 64'(core_en), 1);
    if (restart) begin
      repeat (8) tick();
      pulse_start(32'h700, 32'h780);
    end
    cyc = 0;
    while (!(done_cnt > 0 && !busy) && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("frame_timeout", 64'(cyc < 3000), 1);
    chk("done_pulses", 64'(done_cnt), 1);
    chk("reads_left", 64'(exp_rd.size()), 0);
    chk("writes_left", 64'(exp_wr.size()), 0);
    chk("feeds", 64'(ridx), 64'(reqs.size()));
    chk("range_err_end", 64'(range_err), 64'(oob));
    chk("core_en_end", 64'(core_en), 0);
    repeat (3) tick();
    chk("range_err_sticky", 64'(range_err), 64'(oob));
  endtask

  initial begin
    int cyc, evt0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    src_rand = 0; dst_rand = 0; lat_max = 1; dst_stall = 0;
    hold_addr = '1; rd_acc_evt = 0; done_cnt = 0; ridx = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 0;
    tick();

    run_frame(32'h100, 32'h200, 0, 0, 0);

    hold_addr = ADDR_W'(32'h105);
    run_frame(32'h100, 32'h240, 1, 1, 0);
    hold_addr = '1;

    src_rand = 1; lat_max = 2;
    dst_stall = 20;
    run_frame(32'h180, 32'h300, 0, 0, 0);

    dst_rand = 1;
    run_frame(32'h120, 32'h2A0, 1, 0, 1);

    run_frame(32'h1C0, 32'h340, 1, 0, 0);
    src_rand = 0; dst_rand = 0; lat_max = 3;
    build(32'h140, 32'h380, 0, 0);
    evt0 = rd_acc_evt;
    pulse_start(32'h140, 32'h380);
    cyc = 0;
    while (rd_acc_evt == evt0 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("wait_data_reached", 64'(cyc < 200), 1);
    rst = 1;
    tick();
    check_reset_outputs("mid_reset");
    rst = 0;
    tick();

    lat_max = 2; src_rand = 1; dst_rand = 1;
    run_frame(32'h140, 32'h380, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
